// File: rtl/cic_tdm_filter.sv
// Time-multiplexed CIC decimator. One shared integrator chain and one shared comb
// chain are walked over all microphone channels. Each channel gets two cycles:
// COMPUTE, which registers the integrator sums, and HOLD, which writes them back
// and optionally runs the comb. Per-channel state lives in register arrays.
module cic_tdm_filter #(
   parameter int unsigned CHANNELS   = 8,
   parameter int unsigned STAGES     = 4,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_LSB    = ACC_WIDTH - DATA_WIDTH,
   localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [CHANNELS-1:0]   pdm_data,
   input  logic                  read_enable,
   input  logic                  integrator_enable,
   input  logic                  comb_enable,
   output logic [CH_W-1:0]       channel,
   output logic                  cic_finish,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CH_W-1:0]       data_channel,
   output logic                  data_valid
);

   localparam logic [CH_W-1:0] LastCh = CH_W'(CHANNELS - 1);

   typedef logic [ACC_WIDTH-1:0] acc_t;

   logic [CHANNELS-1:0] pdm_reg;
   logic                phase;        // 0: COMPUTE, 1: HOLD
   logic                finish_pend;  // last HOLD seen; finish goes out next cycle
   acc_t                integ_q [CHANNELS][STAGES];
   acc_t                dly_q   [CHANNELS][STAGES];
   acc_t                sum_q   [STAGES];
   acc_t                sum_d   [STAGES];
   acc_t                comb_y  [STAGES+1];
   acc_t                x_in;

   logic do_compute;
   logic do_hold;

   assign do_compute = !read_enable && integrator_enable && !phase;
   assign do_hold    = !read_enable && integrator_enable && phase;

   // Integrator chain for the current channel: bit 1 -> +1, bit 0 -> -1.
   always_comb begin
      x_in     = pdm_reg[channel] ? acc_t'(1) : '1;
      sum_d[0] = integ_q[channel][0] + x_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
         sum_d[k] = integ_q[channel][k] + sum_d[k-1];
      end
   end

   // Comb chain fed by the last registered integrator sum.
   always_comb begin
      comb_y[0] = sum_q[STAGES-1];
      for (int unsigned k = 0; k < STAGES; k++) begin
         comb_y[k+1] = comb_y[k] - dly_q[channel][k];
      end
   end

   // Frame sequencing: input latch, channel walk, phase toggle, finish pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pdm_reg     <= '0;
         channel     <= '0;
         phase       <= 1'b0;
         finish_pend <= 1'b0;
         cic_finish  <= 1'b0;
      end else begin
         finish_pend <= 1'b0;
         cic_finish  <= finish_pend;
         if (read_enable) begin
            // A restart abandons any partially processed frame.
            pdm_reg <= pdm_data;
            channel <= '0;
            phase   <= 1'b0;
         end else if (integrator_enable) begin
            phase <= !phase;
            if (phase) begin
               if (channel == LastCh) begin
                  finish_pend <= 1'b1;
               end else begin
                  channel <= channel + CH_W'(1);
               end
            end
         end else begin
            phase <= 1'b0;
         end
      end
   end

   // COMPUTE pipeline registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
         end
      end else if (do_compute) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Per-channel integrator and comb delay storage, written back in HOLD.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
               integ_q[c][k] <= '0;
               dly_q[c][k]   <= '0;
            end
         end
      end else if (do_hold) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            integ_q[channel][k] <= sum_q[k];
            if (comb_enable) begin
               dly_q[channel][k] <= comb_y[k];
            end
         end
      end
   end

   // PCM output register; strobe is a single cycle per channel on comb frames.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_out     <= '0;
         data_channel <= '0;
         data_valid   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (do_hold && comb_enable) begin
            data_out     <= comb_y[STAGES][OUT_LSB +: DATA_WIDTH];
            data_channel <= channel;
            data_valid   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cic_tdm_filter.sv
// Directed bench for cic_tdm_filter with a frame-level CIC reference model.
module tb_cic_tdm_filter;

   localparam int CH = 2;
   localparam int N  = 2;

   logic          clk;
   logic          resetn;
   logic [CH-1:0] pdm_data;
   logic          read_enable;
   logic          integrator_enable;
   logic          comb_enable;
   logic [0:0]    channel;
   logic          cic_finish;
   logic [15:0]   data_out;
   logic [0:0]    data_channel;
   logic          data_valid;

   cic_tdm_filter #(
      .CHANNELS   (CH),
      .STAGES     (N),
      .ACC_WIDTH  (16),
      .DATA_WIDTH (16),
      .OUT_LSB    (0)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .pdm_data          (pdm_data),
      .read_enable       (read_enable),
      .integrator_enable (integrator_enable),
      .comb_enable       (comb_enable),
      .channel           (channel),
      .cic_finish        (cic_finish),
      .data_out          (data_out),
      .data_channel      (data_channel),
      .data_valid        (data_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fin_count = 0;

   // Expected events keyed by absolute cycle number.
   int          exp_ch  [int];
   logic [15:0] exp_dat [int];
   int          exp_dch [int];
   bit          exp_fin [int];

   // Reference model: per-channel running sums and comb memories.
   logic [15:0] m_int [CH][N];
   logic [15:0] m_dly [CH][N];
   logic [15:0] m_last [CH];
   logic [15:0] last_dut [CH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < N; k++) begin
            m_int[c][k] = '0;
            m_dly[c][k] = '0;
         end
         m_last[c]   = 16'hDEAD;
         last_dut[c] = 16'hDEAD;
      end
      exp_ch.delete();
      exp_dat.delete();
      exp_dch.delete();
      exp_fin.delete();
      fin_count = 0;
   endtask

   // One full channel update; returns the PCM sample (meaningful on comb frames).
   function automatic logic [15:0] model_channel(input int c, input logic b, input bit comb);
      logic [15:0] acc;
      logic [15:0] y;
      logic [15:0] d;
      acc = b ? 16'd1 : 16'hFFFF;
      for (int k = 0; k < N; k++) begin
         m_int[c][k] = m_int[c][k] + acc;
         acc = m_int[c][k];
      end
      y = acc;
      if (comb) begin
         for (int k = 0; k < N; k++) begin
            d = y - m_dly[c][k];
            m_dly[c][k] = y;
            y = d;
         end
         m_last[c] = y;
      end
      return y;
   endfunction

   // Drives one frame starting now (cycle t); n_ie < 2*CH aborts the frame early.
   task automatic run_frame(input logic [CH-1:0] pdm, input bit comb, input int n_ie,
                            input bit ie_first);
      int t;
      logic [15:0] y;
      t = cyc;
      pdm_data          = pdm;
      read_enable       = 1'b1;
      integrator_enable = ie_first;
      comb_enable       = comb;
      for (int c = 0; c < n_ie / 2; c++) begin
         y = model_channel(c, pdm[c], comb);
         exp_ch[t + 1 + 2*c] = c;
         exp_ch[t + 2 + 2*c] = c;
         if (comb) begin
            exp_dat[t + 3 + 2*c] = y;
            exp_dch[t + 3 + 2*c] = c;
         end
      end
      if (n_ie == 2*CH) begin
         exp_ch[t + 2*CH + 1] = CH - 1;
         exp_ch[t + 2*CH + 2] = CH - 1;
         exp_fin[t + 2 + 2*CH] = 1'b1;
      end
      tick();
      read_enable = 1'b0;
      for (int i = 0; i < n_ie; i++) begin
         integrator_enable = 1'b1;
         tick();
      end
      integrator_enable = 1'b0;
      if (n_ie == 2*CH) begin
         tick();
         tick();
         comb_enable = 1'b0;
      end
   endtask

   task automatic reset_all();
      resetn = 1'b0;
      read_enable = 1'b0;
      integrator_enable = 1'b0;
      comb_enable = 1'b0;
      tick();
      tick();
      model_clear();
      resetn = 1'b1;
      tick();
   endtask

   // Per-cycle comparison against the expectations the frame driver recorded.
   always @(negedge clk) begin
      if (!resetn) begin
         check("rst_channel", 32'(channel), 0);
         check("rst_finish", 32'(cic_finish), 0);
         check("rst_valid", 32'(data_valid), 0);
         check("rst_data", 32'(data_out), 0);
         check("rst_dch", 32'(data_channel), 0);
      end else begin
         if (exp_ch.exists(cyc)) check("channel", 32'(channel), 32'(exp_ch[cyc]));
         check("data_valid", 32'(data_valid), 32'(exp_dat.exists(cyc)));
         if (data_valid && exp_dat.exists(cyc)) begin
            check("data_out", 32'(data_out), 32'(exp_dat[cyc]));
            check("data_channel", 32'(data_channel), 32'(exp_dch[cyc]));
            last_dut[data_channel] = data_out;
         end
         check("cic_finish", 32'(cic_finish), 32'(exp_fin.exists(cyc)));
         if (cic_finish) fin_count++;
      end
   end

   initial begin
      resetn = 1'b0;
      pdm_data = '0;
      read_enable = 1'b0;
      integrator_enable = 1'b0;
      comb_enable = 1'b0;
      model_clear();

      // Reset held while every input toggles.
      for (int i = 0; i < 6; i++) begin
         pdm_data          = CH'($urandom);
         read_enable       = 1'($urandom);
         integrator_enable = 1'($urandom);
         comb_enable       = 1'($urandom);
         tick();
      end
      reset_all();

      // Sequencing: one non-comb frame.
      run_frame(2'b01, 1'b0, 2*CH, 1'b0);
      check("seq_finish_count", 32'(fin_count), 1);

      // DC response, comb every 4th frame.
      reset_all();
      for (int f = 0; f < 16; f++) run_frame(2'b01, (f % 4) == 3, 2*CH, 1'b0);
      check("dc_ch0", 32'(last_dut[0]), 32'h0010);
      check("dc_ch1", 32'(last_dut[1]), 32'hFFF0);
      check("dc_model_ch0", 32'(m_last[0]), 32'h0010);
      check("dc_model_ch1", 32'(m_last[1]), 32'hFFF0);

      // Alternating ch0, constant-one ch1.
      reset_all();
      for (int f = 0; f < 16; f++) begin
         run_frame({1'b1, 1'((f % 2) == 0)}, (f % 4) == 3, 2*CH, 1'b0);
      end
      check("alt_ch0", 32'(last_dut[0]), 32'h0000);
      check("alt_ch1", 32'(last_dut[1]), 32'h0010);
      check("alt_model_ch1", 32'(m_last[1]), 32'h0010);

      // Restart during channel 1 COMPUTE: ch0 gets 5 updates, ch1 only 4.
      reset_all();
      for (int f = 0; f < 3; f++) run_frame(2'b11, 1'b0, 2*CH, 1'b0);
      run_frame(2'b11, 1'b0, 2, 1'b0);
      run_frame(2'b11, 1'b1, 2*CH, 1'b1);
      check("restart_ch0", 32'(last_dut[0]), 32'h000F);
      check("restart_ch1", 32'(last_dut[1]), 32'h000A);
      check("restart_model_ch1", 32'(m_last[1]), 32'h000A);

      // Long all-ones run; the second integrator wraps many times.
      reset_all();
      for (int f = 0; f < 1000; f++) run_frame(2'b11, (f % 4) == 3, 2*CH, 1'b0);
      check("wrap_ch0", 32'(last_dut[0]), 32'h0010);
      check("wrap_ch1", 32'(last_dut[1]), 32'h0010);

      // Asynchronous reset during channel 1 HOLD.
      reset_all();
      for (int f = 0; f < 4; f++) run_frame(2'b11, (f % 4) == 3, 2*CH, 1'b0);
      pdm_data = 2'b11;
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      integrator_enable = 1'b1;
      tick();
      tick();
      tick();
      check("pre_arst_channel", 32'(channel), 1);
      check("pre_arst_data", 32'(data_out), 32'h000A);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_channel", 32'(channel), 0);
      check("arst_data", 32'(data_out), 0);
      check("arst_dch", 32'(data_channel), 0);
      check("arst_valid", 32'(data_valid), 0);
      check("arst_finish", 32'(cic_finish), 0);
      integrator_enable = 1'b0;
      tick();
      reset_all();
      for (int f = 0; f < 4; f++) run_frame(2'b11, (f % 4) == 3, 2*CH, 1'b0);
      check("post_arst_ch0", 32'(last_dut[0]), 32'h000A);
      check("post_arst_ch1", 32'(last_dut[1]), 32'h000A);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
